// File: rtl/csa_arbiter.sv
// Two-requester round-robin front end sharing one 64-bit adder.
// Results go into a single output register that can be consumed and refilled in the same cycle.
module csa_arbiter #(
    parameter logic CIN = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    output logic        req1_ready,
    output logic        res_valid,
    output logic [63:0] res_sum,
    output logic        res_cout,
    output logic        res_id,
    input  logic        res_ready,
    output logic [15:0] busy_cnt
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // The ready signals are a combinational function of the two valids, prio and free.
    // A requester must keep its operands stable while valid is high and ready is low.
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t      state;
    logic        prio;
    logic        free;
    logic        grant;
    logic        grant_id;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [64:0] sum_full;

    assign res_valid = (state == FULL);
    assign free      = (state == EMPTY) || res_ready;

    // Readys are gated by rst_n so that nothing is accepted while reset is asserted.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (rst_n && free) begin
            if (req0_valid && (!req1_valid || !prio))
                req0_ready = 1'b1;
            else if (req1_valid)
                req1_ready = 1'b1;
        end
    end

    assign grant    = req0_ready || req1_ready;
    assign grant_id = req1_ready;
    assign op_a     = grant_id ? req1_a : req0_a;
    assign op_b     = grant_id ? req1_b : req0_b;
    assign sum_full = {1'b0, op_a} + {1'b0, op_b} + {64'd0, CIN};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            prio     <= 1'b0;
            res_sum  <= 64'd0;
            res_cout <= 1'b0;
            res_id   <= 1'b0;
            busy_cnt <= 16'd0;
        end else begin
            case (state)
                EMPTY:   if (grant) state <= FULL;
                FULL:    if (res_ready && !grant) state <= EMPTY;
                default: state <= EMPTY;
            endcase
            if (grant) begin
                res_sum  <= sum_full[63:0];
                res_cout <= sum_full[64];
                res_id   <= grant_id;
                prio     <= ~grant_id;
                if (busy_cnt != 16'hFFFF)
                    busy_cnt <= busy_cnt + 16'd1;
            end
        end
    end

endmodule
